// File: rtl/spi_flash_read_seq.sv
// SPI-flash READ (0x03) command sequencer: frames opcode + 24-bit address + dummy
// bytes toward the byte engine and streams the received data bytes out ready/valid.
module spi_flash_read_seq #(
  parameter int         LEN_W   = 16,
  parameter logic [7:0] READ_OP = 8'h03,
  parameter int         TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [23:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             byte_req,
  output logic [7:0]       byte_tx,
  input  logic             byte_done,
  input  logic [7:0]       byte_rx,
  output logic             cs_hold
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, OP, A2, A1, A0, DREQ, DWAIT, DOUT, FIN
  } state_e;

  state_e           state_q, state_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             byte_req_q, byte_req_d;
  logic [7:0]       byte_tx_q, byte_tx_d;
  logic             err_q, err_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic wait_st, got_done, timeout;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      byte_req_q <= 1'b0;
      byte_tx_q  <= '0;
      err_q      <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      byte_req_q <= byte_req_d;
      byte_tx_q  <= byte_tx_d;
      err_q      <= err_d;
      wd_q       <= wd_d;
    end
  end

  // The request cycle itself never accepts byte_done, so a stale pulse cannot complete a new byte.
  assign wait_st  = state_q inside {OP, A2, A1, A0, DREQ, DWAIT};
  assign got_done = byte_done && !byte_req_q && (state_q inside {OP, A2, A1, A0, DWAIT});
  assign timeout  = wait_st && !got_done && (wd_q == WD_W'(TIMEOUT - 1));

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    byte_req_d = 1'b0;
    byte_tx_d  = byte_tx_q;
    err_d      = 1'b0;
    wd_d       = wait_st ? wd_q + WD_W'(1) : '0;

    unique case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d = cmd_addr;
        rem_d  = cmd_len;
        if (cmd_len == '0) begin
          state_d = FIN;
        end else begin
          state_d    = OP;
          byte_req_d = 1'b1;
          byte_tx_d  = READ_OP;
        end
      end
      OP: if (got_done) begin
        state_d    = A2;
        byte_req_d = 1'b1;
        byte_tx_d  = addr_q[23:16];
      end
      A2: if (got_done) begin
        state_d    = A1;
        byte_req_d = 1'b1;
        byte_tx_d  = addr_q[15:8];
      end
      A1: if (got_done) begin
        state_d    = A0;
        byte_req_d = 1'b1;
        byte_tx_d  = addr_q[7:0];
      end
      A0: if (got_done) begin
        state_d    = DREQ;
        byte_req_d = 1'b1;
        byte_tx_d  = 8'h00;
      end
      DREQ: state_d = DWAIT;
      DWAIT: if (got_done) begin
        state_d    = DOUT;
        rd_data_d  = byte_rx;
        rd_valid_d = 1'b1;
      end
      // Next dummy byte is only requested after the consumer takes the current one.
      DOUT: if (rd_ready) begin
        rd_valid_d = 1'b0;
        rem_d      = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = FIN;
        end else begin
          state_d    = DREQ;
          byte_req_d = 1'b1;
          byte_tx_d  = 8'h00;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d    = IDLE;
      err_d      = 1'b1;
      rd_valid_d = 1'b0;
      byte_req_d = 1'b0;
    end
    if (byte_req_d) wd_d = '0;
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = !(state_q inside {IDLE, FIN});
  assign cs_hold   = busy;
  assign done      = (state_q == FIN);
  assign err       = err_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign byte_req  = byte_req_q;
  assign byte_tx   = byte_tx_q;

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Bench for spi_flash_read_seq: byte-engine model, random traffic, and a frame-level
// reference model (expected byte stream built from opcode/address/length).
module tb_spi_flash_read_seq;

  localparam int         LEN_W   = 4;
  localparam logic [7:0] READ_OP = 8'h03;
  localparam int         TIMEOUT = 1024;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [23:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             busy, done, err;
  logic             byte_req;
  logic [7:0]       byte_tx;
  logic             byte_done;
  logic [7:0]       byte_rx;
  logic             cs_hold;

  spi_flash_read_seq #(.LEN_W(LEN_W), .READ_OP(READ_OP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err(err),
    .byte_req(byte_req), .byte_tx(byte_tx), .byte_done(byte_done), .byte_rx(byte_rx),
    .cs_hold(cs_hold)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  logic [7:0]  tx_log[$], rx_log[$], rd_log[$], exp_tx[$];
  bit          exp_dat[$];
  int          req_cyc[$], acc_cyc[$], done_cyc[$];
  logic [23:0] acc_addr[$];
  int          done_n, err_n, cs_viol, stable_viol, stall_req, stall_chg;
  bit          in_stall;
  logic [7:0]  stall_data;

  int         eng_cnt = 0, eng_delay = 16, drop_idx = -1, byte_idx = 0, rr_mode = 0;
  bit         eng_rand_dly = 1'b0, fixed_rx = 1'b0, inject_late = 1'b0;
  logic [7:0] eng_rx;

  // Byte engine, consumer and monitor: drive at the falling edge, sample 3 ns later.
  initial begin
    byte_done = 1'b0;
    byte_rx   = 8'h00;
    rd_ready  = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      byte_done = 1'b0;
      if (rst) begin
        eng_cnt = 0;
      end else if (inject_late) begin
        byte_done   = 1'b1;
        byte_rx     = 8'h5A;
        inject_late = 1'b0;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          byte_done = 1'b1;
          byte_rx   = eng_rx;
        end
      end
      case (rr_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'b0;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      #3;
      if (cmd_valid && cmd_ready) begin
        acc_addr.push_back(cmd_addr);
        acc_cyc.push_back(cyc);
        byte_idx = 0;
      end
      if (byte_req) begin
        tx_log.push_back(byte_tx);
        req_cyc.push_back(cyc);
        if (!cs_hold) cs_viol++;
        eng_rx = fixed_rx ? 8'hA0 + 8'(byte_idx) : 8'($urandom);
        rx_log.push_back(eng_rx);
        if (byte_idx != drop_idx)
          eng_cnt = eng_rand_dly ? int'($urandom_range(1, 20)) : eng_delay;
        byte_idx++;
      end else if (eng_cnt > 0 && tx_log.size() > 0 && byte_tx != tx_log[$]) begin
        stable_viol++;
      end
      if (rd_valid && rd_ready) rd_log.push_back(rd_data);
      if (done) begin
        done_n++;
        done_cyc.push_back(cyc);
      end
      if (err) err_n++;
      if (in_stall) begin
        if (byte_req) stall_req++;
        if (rd_data != stall_data) stall_chg++;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {9'b0, cmd_ready, busy, done, err, rd_valid, rd_data, byte_req, byte_tx, cs_hold};
  endfunction

  task automatic clear_logs();
    tx_log.delete(); rx_log.delete(); rd_log.delete(); exp_tx.delete(); exp_dat.delete();
    req_cyc.delete(); acc_cyc.delete(); done_cyc.delete(); acc_addr.delete();
    done_n = 0; err_n = 0; cs_viol = 0; stable_viol = 0; stall_req = 0; stall_chg = 0;
  endtask

  // Reference frame: opcode, address MSB-first, then one dummy byte per data byte.
  task automatic add_exp(input logic [23:0] addr, input int len);
    exp_tx.push_back(READ_OP);      exp_dat.push_back(1'b0);
    exp_tx.push_back(addr[23:16]);  exp_dat.push_back(1'b0);
    exp_tx.push_back(addr[15:8]);   exp_dat.push_back(1'b0);
    exp_tx.push_back(addr[7:0]);    exp_dat.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      exp_tx.push_back(8'h00);
      exp_dat.push_back(1'b1);
    end
  endtask

  task automatic check_seq(input string tag);
    logic [7:0] exp_rd[$];
    check({tag, "_ntx"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), tx_log[i], exp_tx[i]);
    for (int i = 0; i < exp_dat.size() && i < rx_log.size(); i++)
      if (exp_dat[i]) exp_rd.push_back(rx_log[i]);
    check({tag, "_nrd"}, rd_log.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), rd_log[i], exp_rd[i]);
    check({tag, "_cs"}, cs_viol, 0);
    check({tag, "_txstable"}, stable_viol, 0);
  endtask

  task automatic issue(input string tag, input logic [23:0] addr, input logic [LEN_W-1:0] len);
    int n0;
    n0 = acc_addr.size();
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && acc_addr.size() == n0; i++) tick();
    check({tag, "_accept"}, acc_addr.size(), n0 + 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n, input int bound);
    for (int i = 0; i < bound && done_n < n; i++) tick();
    check({tag, "_done"}, done_n, n);
  endtask

  task automatic run_txn(input string tag, input logic [23:0] addr, input logic [LEN_W-1:0] len);
    clear_logs();
    add_exp(addr, int'(len));
    issue(tag, addr, len);
    wait_done(tag, 1, 4000);
    repeat (3) tick();
    check_seq(tag);
    check({tag, "_err"}, err_n, 0);
    check({tag, "_ndone"}, done_n, 1);
  endtask

  initial begin
    logic [23:0] a;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    repeat (3) tick();
    check("rst_outs", outs(), 32'h0040_0000);
    rst = 1'b0;
    tick();

    // Basic read with fixed engine latency and indexed rx bytes.
    fixed_rx = 1'b1; eng_delay = 16;
    run_txn("basic", 24'h123456, 2);
    check("basic_rd0", rd_log.size() > 0 ? rd_log[0] : 8'hxx, 8'hA4);
    check("basic_rd1", rd_log.size() > 1 ? rd_log[1] : 8'hxx, 8'hA5);
    fixed_rx = 1'b0;

    // Zero length: done the cycle after accept, ready again one cycle later.
    clear_logs();
    issue("zero", 24'hABCDEF, 0);
    check("zero_done_now", done, 1'b1);
    check("zero_ready_low", cmd_ready, 1'b0);
    tick();
    check("zero_ready_back", cmd_ready, 1'b1);
    check("zero_done_gone", done, 1'b0);
    tick();
    check("zero_lat", (done_cyc.size() > 0 && acc_cyc.size() > 0) ? done_cyc[0] - acc_cyc[0] : -1, 1);
    check("zero_ntx", tx_log.size(), 0);

    // Backpressure: consumer stalls 50 cycles on the first data byte.
    clear_logs();
    eng_delay = 5; rr_mode = 1;
    add_exp(24'h00F00D, 3);
    issue("bp", 24'h00F00D, 3);
    for (int i = 0; i < 500 && !rd_valid; i++) tick();
    check("bp_valid", rd_valid, 1'b1);
    stall_data = rd_data; in_stall = 1'b1;
    repeat (50) tick();
    in_stall = 1'b0; rr_mode = 0;
    wait_done("bp", 1, 2000);
    repeat (3) tick();
    check("bp_stall_req", stall_req, 0);
    check("bp_stall_chg", stall_chg, 0);
    check_seq("bp");
    check("bp_err", err_n, 0);

    // Watchdog: A1 byte never answered; a late byte_done must be ignored.
    clear_logs();
    eng_delay = 8; drop_idx = 2;
    issue("to", 24'h55AA33, 2);
    for (int i = 0; i < 1500 && !err; i++) tick();
    check("to_seen", err, 1'b1);
    check("to_lat", req_cyc.size() > 2 ? cyc - req_cyc[2] : -1, TIMEOUT);
    check("to_cs", cs_hold, 1'b0);
    check("to_busy", busy, 1'b0);
    check("to_rdv", rd_valid, 1'b0);
    drop_idx = -1;
    tick();
    inject_late = 1'b1;
    repeat (10) tick();
    check("to_ntx", tx_log.size(), 3);
    check("to_nerr", err_n, 1);
    check("to_ndone", done_n, 0);
    check("to_idle", cmd_ready, 1'b1);
    run_txn("after_to", 24'h0C0FFE, 2);

    // Reset while waiting for the second data byte.
    clear_logs();
    eng_delay = 10;
    issue("mrst", 24'h777777, 3);
    for (int i = 0; i < 500 && tx_log.size() < 6; i++) tick();
    check("mrst_reach", tx_log.size(), 6);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("mrst_outs", outs(), 32'h0040_0000);
    rst = 1'b0;
    repeat (40) tick();
    check("mrst_done", done_n, 0);
    check("mrst_err", err_n, 0);
    check("mrst_nrd", rd_log.size(), 1);

    // Busy rejection: second command held valid during the first transaction.
    clear_logs();
    eng_delay = 4;
    add_exp(24'h111111, 2);
    add_exp(24'h222222, 1);
    cmd_addr = 24'h111111; cmd_len = 2; cmd_valid = 1'b1;
    for (int i = 0; i < 100 && acc_addr.size() < 1; i++) tick();
    cmd_addr = 24'h222222; cmd_len = 1;
    for (int i = 0; i < 1000 && acc_addr.size() < 2; i++) tick();
    cmd_valid = 1'b0;
    wait_done("busy", 2, 1000);
    repeat (10) tick();
    check("busy_nacc", acc_addr.size(), 2);
    check("busy_addr1", acc_addr.size() > 1 ? acc_addr[1] : 24'hx, 24'h222222);
    check("busy_acc_cyc", (acc_cyc.size() > 1 && done_cyc.size() > 0) ? acc_cyc[1] - done_cyc[0] : -1, 1);
    check_seq("busy");

    // Maximum length for the counter width must complete without wrap.
    eng_rand_dly = 1'b1; rr_mode = 2;
    run_txn("maxlen", 24'hFEDCBA, {LEN_W{1'b1}});

    // Random traffic.
    for (int t = 0; t < 6; t++) begin
      a = 24'($urandom);
      run_txn($sformatf("rnd%0d", t), a, LEN_W'($urandom_range(1, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
